// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: latches the PC, runs a req/ack transaction with
// instruction memory, registers the returned word with its address and offers
// it to decode over valid/ready. pc_hold keeps the PC recirculating until
// decode takes the instruction. A flush abandons any fetch in flight, and a
// memory that never answers parks the stage in a sticky error state that only
// reset clears.
// TIMEOUT must lie in 2..255 (the wait counter is 8 bits wide).
module instr_fetch_stage #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_hold,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              fetch_err,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } state_t;

    // Last cycle REQ may wait before giving up on the memory.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    // Fetch sequencer: all outputs except pc_hold are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            inst_valid  <= 1'b0;
            inst_data   <= '0;
            inst_pc     <= '0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b0;
                        wait_cnt   <= '0;
                    end else begin
                        imem_addr <= pc_addr;
                        imem_req  <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (flush) begin
                        // Any ack arriving with the flush belongs to the old path.
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= IDLE;
                    end else if (imem_ack) begin
                        inst_data  <= imem_rdata;
                        inst_pc    <= imem_addr;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                HOLD: begin
                    if (flush) begin
                        // Flush wins over a simultaneous ready: nothing is handed off.
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= IDLE;
                    end else if (inst_ready) begin
                        inst_valid  <= 1'b0;
                        fetch_count <= fetch_count + 32'd1;
                        state       <= IDLE;
                    end
                end

                ERR: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    fetch_err  <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Let the PC advance only on a real handoff or a redirect.
    always_comb begin
        pc_hold = reset | (~(inst_valid & inst_ready) & ~flush);
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current PC address, issues a request to instruction memory with a req/ack handshake, and registers the returned word plus its PC.
- Presents the result to decode over a valid/ready handshake.
- Drives pc_hold so the PC-input mux recirculates the current address until decode accepts the instruction. Supports a flush on branch/jump redirect and a memory-timeout error state.

Parameters:
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction word width
- TIMEOUT, 16, max cycles REQ waits for imem_ack before ERR; legal range 2..255

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- pc_addr  in  ADDR_W  current PC output; PC updates on negedge, stable at posedge
- pc_hold  out  1  1 = PC input mux recirculates current address
- flush  in  1  redirect pulse from branch/jump resolution
- imem_req  out  1  instruction memory request
- imem_addr  out  ADDR_W  request address
- imem_ack  in  1  memory response valid; sampled only while imem_req=1
- imem_rdata  in  DATA_W  instruction word, valid with imem_ack
- inst_valid  out  1  instruction available to decode
- inst_data  out  DATA_W  fetched instruction
- inst_pc  out  ADDR_W  address of inst_data
- inst_ready  in  1  decode accepts instruction
- fetch_err  out  1  sticky memory-timeout flag
- fetch_count  out  32  count of instructions handed to decode; wraps 2^32-1 -> 0

Behaviour:
- States: IDLE, REQ, HOLD, ERR. Encoding is free; there is no state output.
- Reset (highest priority, any state):
  - state=IDLE.
  - imem_req=0, imem_addr=0, inst_valid=0, inst_data=0, inst_pc=0.
  - fetch_err=0, fetch_count=0, timeout counter=0.
- pc_hold is combinational: pc_hold = ~(inst_valid & inst_ready) & ~flush. Its value during reset is 1.
- IDLE:
  - imem_addr<=pc_addr, imem_req<=1, counter<=0, ->REQ.
  - Exactly one capture per entry.
- REQ:
  - imem_req=1; imem_addr held stable.
  - imem_ack=1: inst_data<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1, imem_req<=0, ->HOLD.
  - No ack and counter==TIMEOUT-1: imem_req<=0, fetch_err<=1, ->ERR.
  - Otherwise counter<=counter+1.
- HOLD:
  - inst_valid=1; inst_data and inst_pc stable.
  - On inst_ready=1 (handoff): inst_valid<=0, fetch_count<=fetch_count+1, ->IDLE.
  - The PC advances on the following negedge, so IDLE captures the new address.
- ERR:
  - imem_req=0, inst_valid=0, fetch_err=1.
  - Exits only on reset; flush ignored.
- Flush (priority below reset, above ack/ready), in IDLE/REQ/HOLD:
  - inst_valid<=0, imem_req<=0, counter<=0, ->IDLE.
  - An ack in the same cycle is discarded. Memory must tolerate a dropped req.
  - inst_ready in the same cycle is ignored: no handoff, no count.
- Latency: zero-wait memory gives inst_valid 2 posedges after IDLE entry. Maximum throughput is 1 instruction per 3 cycles.
- Ack while imem_req=0 is ignored.
- Wrap-around: pc_addr and inst_pc pass through unmodified; no address arithmetic in this block.

Test Plan:
- Reset → outputs:
  - Hold reset 3 cycles with pc_addr=0x40, imem_ack=1 → all outputs 0, pc_hold=1.
  - First posedge after release captures imem_addr=0x40 and raises imem_req.
- Zero-wait streaming:
  - Memory acks in the same cycle; inst_ready tied 1; PC steps 0,1,2 → inst_pc/inst_data pairs (0,M[0]),(1,M[1]),(2,M[2]).
  - Spacing is 3 cycles; pc_hold low exactly during each handoff cycle; fetch_count=3.
- Wait states and backpressure:
  - Ack after 3 cycles, then inst_ready low 4 cycles → imem_addr stable throughout REQ.
  - inst_data/inst_pc stable while inst_ready is low; pc_hold=1 until the ready cycle; fetch_count increments once.
- Flush:
  - Flush together with imem_ack in REQ (rdata=0xDEADBEEF) → inst_valid stays 0; 0xDEADBEEF never appears on inst_data.
  - Next cycle is IDLE and captures the redirected pc_addr.
  - Flush in HOLD with inst_ready=1 → no count increment.
- Timeout (TIMEOUT=4):
  - Never ack → imem_req high exactly 4 cycles, then fetch_err=1, imem_req=0.
  - fetch_err stays set despite flush and ack; reset clears it and fetching resumes.
- fetch_count wrap:
  - Force the count to 0xFFFFFFFF, then one handoff → fetch_count=0.
